// File: rtl/cache_sa_pkg.sv
// cache_sa_pkg: shared types and helpers for the set-associative data cache.
//   state_e      : miss-handling FSM states
//   safe_width   : index width that never collapses to zero bits
//   tag_width    : number of tag bits left after byte/offset/index bits
//   byte_merge   : per-lane merge of a store into an existing word
package cache_sa_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2,
    COMMIT = 2'd3
  } state_e;

  // Width of a selector for n items; at least one bit so vectors stay legal.
  function automatic int safe_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  // Tag bits = 32 address bits minus byte, word-offset and index bits.
  function automatic int tag_width(input int off_w, input int idx_w);
    return 32 - 2 - off_w - idx_w;
  endfunction

  // Replace the byte lanes selected by we; all other lanes keep old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  we);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        merged[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/cache_sa_way.sv
// cache_sa_way: one way of the cache, N_SETS lines of valid/dirty/tag/data.
// Ports:
//   clk, rst_i            : clock, synchronous active-high reset (clears valid/dirty)
//   idx                   : set index used for both the read and all writes
//   line_valid/dirty/tag/data : combinational view of the indexed line
//   fill_en, fill_tag, fill_data : install a whole line (valid=1, dirty=0)
//   word_en, word_sel, word_data, word_be : byte-masked word store, marks dirty
//   clean_en              : clear dirty after write-back
module cache_sa_way #(
  parameter int N_SETS           = 8,
  parameter int N_WORDS_PER_LINE = 8,
  parameter int IDX_W            = 3,
  parameter int OFF_W            = 3,
  parameter int TAG_W            = 24
) (
  input  logic                                 clk,
  input  logic                                 rst_i,
  input  logic [IDX_W-1:0]                     idx,
  output logic                                 line_valid,
  output logic                                 line_dirty,
  output logic [TAG_W-1:0]                     line_tag,
  output logic [N_WORDS_PER_LINE-1:0][31:0]    line_data,
  input  logic                                 fill_en,
  input  logic [TAG_W-1:0]                     fill_tag,
  input  logic [N_WORDS_PER_LINE-1:0][31:0]    fill_data,
  input  logic                                 word_en,
  input  logic [OFF_W-1:0]                     word_sel,
  input  logic [31:0]                          word_data,
  input  logic [3:0]                           word_be,
  input  logic                                 clean_en
);
  import cache_sa_pkg::*;

  logic [N_SETS-1:0]                      valid_r;
  logic [N_SETS-1:0]                      dirty_r;
  logic [TAG_W-1:0]                       tag_r  [N_SETS];
  logic [N_WORDS_PER_LINE-1:0][31:0]      data_r [N_SETS];

  assign line_valid = valid_r[idx];
  assign line_dirty = dirty_r[idx];
  assign line_tag   = tag_r[idx];
  assign line_data  = data_r[idx];

  // Line state bits: the only part of the array that reset touches.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      valid_r <= {N_SETS{1'b0}};
      dirty_r <= {N_SETS{1'b0}};
    end else if (fill_en) begin
      valid_r[idx] <= 1'b1;
      dirty_r[idx] <= 1'b0;
    end else if (word_en) begin
      dirty_r[idx] <= 1'b1;
    end else if (clean_en) begin
      dirty_r[idx] <= 1'b0;
    end
  end

  // Tag and data storage; contents are meaningless until the line is valid.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_r[idx]  <= fill_tag;
      data_r[idx] <= fill_data;
    end else if (word_en) begin
      data_r[idx][word_sel] <= byte_merge(data_r[idx][word_sel], word_data, word_be);
    end
  end

endmodule

// File: rtl/cache_sa.sv
// cache_sa: N-way set-associative, write-back, write-allocate data cache.
// Core side : read_i/write_i held until the one-cycle valid_o; we_i byte
//             enables, addr_i byte address, data_i store data, data_o load data.
// Memory side: one outstanding word; mem_read_o/mem_write_o held until
//             mem_valid_i, mem_addr_o word address, mem_wdata_o/mem_rdata_i.
// Hits complete in the same cycle; misses walk IDLE->[WB]->REFILL->COMMIT->IDLE.
// Optional CACHE_SA_STATS_EN adds saturating hit_cnt_o / miss_cnt_o.
module cache_sa
  import cache_sa_pkg::*;
#(
  parameter int N_SETS           = 8,
  parameter int N_WAYS           = 2,
  parameter int N_WORDS_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_valid_i
`ifdef CACHE_SA_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int OFF_W = $clog2(N_WORDS_PER_LINE);
  localparam int IDX_B = $clog2(N_SETS);
  localparam int IDX_W = safe_width(N_SETS);
  localparam int TAG_W = tag_width(OFF_W, IDX_B);
  localparam int WAY_W = safe_width(N_WAYS);
  localparam int CNT_W = OFF_W + 1;

  typedef logic [N_WORDS_PER_LINE-1:0][31:0] line_t;

  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WAY_W-1:0]   victim_r;
  logic [WAY_W-1:0]   ptr_r [N_SETS];
  line_t              buf_r;

  logic [TAG_W-1:0]   req_tag_s;
  logic [IDX_W-1:0]   req_idx_s;
  logic [OFF_W-1:0]   req_off_s;
  logic [OFF_W-1:0]   cnt_off_s;
  logic               last_s;
  logic               req_s;
  logic               hit_any_s;
  logic [WAY_W-1:0]   hit_way_s;
  logic               idle_hit_s;
  logic               miss_s;
  logic [WAY_W-1:0]   cur_ptr_s;
  logic               unused_s;

  logic               way_valid_s [N_WAYS];
  logic               way_dirty_s [N_WAYS];
  logic [TAG_W-1:0]   way_tag_s   [N_WAYS];
  line_t              way_line_s  [N_WAYS];
  logic [N_WAYS-1:0]  fill_en_s;
  logic [N_WAYS-1:0]  word_en_s;
  logic [N_WAYS-1:0]  clean_en_s;

`ifdef CACHE_SA_STATS_EN
  logic [31:0]        hit_cnt_r;
  logic [31:0]        miss_cnt_r;
  assign hit_cnt_o  = hit_cnt_r;
  assign miss_cnt_o = miss_cnt_r;
`endif

  // Rebuild a word-aligned memory address from line coordinates.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] idx,
                                            input logic [OFF_W-1:0] off);
    return (32'(tag) << (2 + OFF_W + IDX_B)) |
           (32'(idx) << (2 + OFF_W)) |
           (32'(off) << 2);
  endfunction

  assign req_tag_s = addr_i[31 -: TAG_W];
  // Masking with N_SETS-1 keeps a single-set cache at index 0.
  assign req_idx_s = IDX_W'((addr_i >> (2 + OFF_W)) & 32'(N_SETS - 1));
  assign req_off_s = addr_i[2 +: OFF_W];
  assign cnt_off_s = cnt_r[OFF_W-1:0];
  assign last_s    = (cnt_r == CNT_W'(N_WORDS_PER_LINE - 1));
  assign req_s     = read_i | write_i;
  assign cur_ptr_s = ptr_r[req_idx_s];
  assign unused_s  = ^addr_i[1:0];

  for (genvar w = 0; w < N_WAYS; w++) begin : g_way
    cache_sa_way #(
      .N_SETS           (N_SETS),
      .N_WORDS_PER_LINE (N_WORDS_PER_LINE),
      .IDX_W            (IDX_W),
      .OFF_W            (OFF_W),
      .TAG_W            (TAG_W)
    ) u_way (
      .clk        (clk),
      .rst_i      (rst_i),
      .idx        (req_idx_s),
      .line_valid (way_valid_s[w]),
      .line_dirty (way_dirty_s[w]),
      .line_tag   (way_tag_s[w]),
      .line_data  (way_line_s[w]),
      .fill_en    (fill_en_s[w]),
      .fill_tag   (req_tag_s),
      .fill_data  (buf_r),
      .word_en    (word_en_s[w]),
      .word_sel   (req_off_s),
      .word_data  (data_i),
      .word_be    (we_i),
      .clean_en   (clean_en_s[w])
    );
  end

  // Tag compare across the indexed set; at most one way can match.
  always_comb begin
    hit_any_s = 1'b0;
    hit_way_s = {WAY_W{1'b0}};
    for (int w = 0; w < N_WAYS; w++) begin
      if (way_valid_s[w] && (way_tag_s[w] == req_tag_s)) begin
        hit_any_s = 1'b1;
        hit_way_s = WAY_W'(w);
      end else begin
        hit_any_s = hit_any_s;
      end
    end
  end

  assign idle_hit_s = !rst_i && (state_r == IDLE) && req_s && hit_any_s;
  assign miss_s     = !rst_i && (state_r == IDLE) && req_s && !hit_any_s;

  // Per-way write strobes; all are suppressed while reset is asserted.
  always_comb begin
    fill_en_s  = {N_WAYS{1'b0}};
    word_en_s  = {N_WAYS{1'b0}};
    clean_en_s = {N_WAYS{1'b0}};
    for (int w = 0; w < N_WAYS; w++) begin
      fill_en_s[w]  = !rst_i && (state_r == COMMIT) && (victim_r == WAY_W'(w));
      word_en_s[w]  = idle_hit_s && write_i && (hit_way_s == WAY_W'(w));
      clean_en_s[w] = !rst_i && (state_r == WB) && mem_valid_i && last_s &&
                      (victim_r == WAY_W'(w));
    end
  end

  // Miss FSM, word counter, victim/pointer bookkeeping and statistics.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      victim_r <= {WAY_W{1'b0}};
      buf_r    <= {(N_WORDS_PER_LINE*32){1'b0}};
      for (int s = 0; s < N_SETS; s++) begin
        ptr_r[s] <= {WAY_W{1'b0}};
      end
`ifdef CACHE_SA_STATS_EN
      hit_cnt_r  <= 32'h0;
      miss_cnt_r <= 32'h0;
`endif
    end else begin
`ifdef CACHE_SA_STATS_EN
      if (idle_hit_s && (hit_cnt_r != 32'hFFFF_FFFF)) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (miss_s && (miss_cnt_r != 32'hFFFF_FFFF)) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
`endif
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            victim_r <= cur_ptr_s;
            cnt_r    <= {CNT_W{1'b0}};
            // Only a valid dirty victim needs to be written back first.
            if (way_valid_s[cur_ptr_s] && way_dirty_s[cur_ptr_s]) begin
              state_r <= WB;
            end else begin
              state_r <= REFILL;
            end
          end
        end
        WB: begin
          if (mem_valid_i) begin
            if (last_s) begin
              state_r <= REFILL;
              cnt_r   <= {CNT_W{1'b0}};
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        REFILL: begin
          if (mem_valid_i) begin
            buf_r[cnt_off_s] <= mem_rdata_i;
            if (last_s) begin
              state_r <= COMMIT;
              cnt_r   <= {CNT_W{1'b0}};
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          // Round-robin: wrap explicitly so non-full pointer ranges also work.
          if (cur_ptr_s == WAY_W'(N_WAYS - 1)) begin
            ptr_r[req_idx_s] <= {WAY_W{1'b0}};
          end else begin
            ptr_r[req_idx_s] <= cur_ptr_s + WAY_W'(1);
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Core and memory outputs, decoded from the FSM state and forced to 0 in reset.
  always_comb begin
    valid_o     = idle_hit_s;
    data_o      = 32'h0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (idle_hit_s && read_i) begin
      data_o = way_line_s[hit_way_s][req_off_s];
    end else begin
      data_o = 32'h0;
    end
    if (rst_i) begin
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
    end else begin
      case (state_r)
        WB: begin
          mem_write_o = 1'b1;
          mem_addr_o  = line_addr(way_tag_s[victim_r], req_idx_s, cnt_off_s);
          mem_wdata_o = way_line_s[victim_r][cnt_off_s];
        end
        REFILL: begin
          mem_read_o = 1'b1;
          mem_addr_o = line_addr(req_tag_s, req_idx_s, cnt_off_s);
        end
        IDLE, COMMIT: begin
          mem_read_o = 1'b0;
        end
        default: begin
          mem_read_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_sa.md
Name: cache_sa

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache. Successor to the single-set instruction/data cache prototype.
- Sits between a core load/store port and a simple single-word memory port; an external lsu adapts that port to the wishbone bus.
- Adds over the prototype:
  - configurable sets/ways/line size
  - per-set round-robin victim selection
  - an explicit miss FSM
  - correct byte-enable merging
  - an optional statistics block

Parameters:
- N_SETS, 8, number of sets; power of two, >=1.
- N_WAYS, 2, associativity; power of two, >=1.
- N_WORDS_PER_LINE, 8, 32-bit words per line; power of two, >=2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- read_i  in  1  load request; held until valid_o.
- write_i  in  1  store request; held until valid_o; read_i and write_i are never both high.
- we_i  in  4  byte enables for stores; ignored on loads.
- addr_i  in  32  byte address; bits [1:0] ignored; stable while request is held.
- data_i  in  32  store data, byte lanes aligned to we_i.
- data_o  out  32  load data; valid only when valid_o=1 on a load, else 0.
- valid_o  out  1  one-cycle completion pulse for the held request.
- mem_read_o  out  1  memory word read request.
- mem_write_o  out  1  memory word write request.
- mem_addr_o  out  32  word-aligned memory address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data, valid with mem_valid_i.
- mem_valid_i  in  1  one-cycle completion of the current memory word.

Behaviour:
- Address split (bits LSB first):
  - [1:0] byte
  - OFF=log2(N_WORDS_PER_LINE) word offset bits
  - IDX=log2(N_SETS) index bits
  - tag = remaining TAG=32-2-OFF-IDX bits
- Per line: valid, dirty, tag, data. Per set: victim pointer of log2(N_WAYS) bits.
- Reset clears all valid, dirty and victim pointers, and sets the FSM to IDLE. Line data is not reset. All outputs are 0 during and after reset. Reset mid-miss aborts the miss immediately; the line being refilled stays invalid.
- FSM states: IDLE, WB, REFILL, COMMIT.
- IDLE:
  - Hit = any way in the indexed set with valid and matching tag.
  - On a hit, valid_o=1 in the same cycle (zero-wait hit).
  - Load hit: data_o = the addressed word.
  - Store hit: each byte lane with we_i[b]=1 is replaced by data_i. Other bytes are preserved, for any we_i pattern including 0000. The line becomes dirty at the clock edge.
  - On a miss, latch the victim = the set's pointer way. If the victim is valid and dirty, go to WB; otherwise go to REFILL.
- WB:
  - Write the victim's words 0..N_WORDS_PER_LINE-1 in order.
  - mem_addr_o = {victim tag, index, word counter, 2'b00}.
  - Hold mem_write_o=1 per word until mem_valid_i, then advance the counter.
  - After the last word: clear dirty, go to REFILL.
- REFILL:
  - Read words 0..N-1 of the line of addr_i; mem_addr_o = {addr_i tag, index, counter, 2'b00}.
  - Hold mem_read_o=1 until mem_valid_i.
  - Each returned word is stored in a refill buffer at the counter position.
  - After the last word, go to COMMIT.
- COMMIT:
  - Write the buffer into the victim way; set valid, tag = addr_i tag, dirty=0.
  - Victim pointer of the set increments modulo N_WAYS (wrap).
  - Go to IDLE. The request then hits next cycle, so miss latency = words + 2 cycles, plus N words if the victim was dirty.
- The word counter is log2(N_WORDS_PER_LINE)+1 bits. It resets to 0 on entering WB or REFILL.
- mem_read_o and mem_write_o are never high together, and are both 0 in IDLE and COMMIT.
- At most one outstanding memory word.
- If read_i and write_i are dropped mid-miss, the miss still completes and the line is installed. No valid_o is issued.

Optional Feature:
- CACHE_SA_STATS_EN defined:
  - Adds ports hit_cnt_o (out, 32) and miss_cnt_o (out, 32).
  - hit_cnt_o increments on each IDLE hit with valid_o=1.
  - miss_cnt_o increments on each IDLE->WB/REFILL transition.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- CACHE_SA_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_sa_pkg:
  - state enum (IDLE, WB, REFILL, COMMIT)
  - function byte_merge(old_word, new_word, we) returning 32 bits
  - localparam helper for tag width
- Sub-module cache_sa_way: one way, with an array of N_SETS lines of tag/valid/dirty/data.
  - Combinational read by index.
  - Synchronous line write, word write with byte mask, and dirty/valid update.
- cache_sa instantiates N_WAYS instances.

Test Plan:
- Reset, then load 0x100 with N_WAYS=2 -> REFILL reads 0x100..0x11C, valid_o after 10 cycles, data_o = memory[0x100]; repeating the load gives valid_o the same cycle.
- Store we_i=0011, data_i=0xAAAA5555 to a word holding 0x12345678 -> read back 0x12345555; line dirty.
- Three lines mapping to the same set (0x000, 0x100, 0x200 with N_SETS=8, 8 words) -> the third miss evicts way 0 (round-robin); the fourth access to 0x000 misses.
- Dirty victim eviction -> 8 mem_write_o words at the old tag address with the stored data, then 8 reads; memory model holds the merged data.
- rst_i asserted during REFILL word 3 -> outputs 0 next cycle; re-request misses and refills from word 0.
- CACHE_SA_STATS_EN: 5 hits and 2 misses -> hit_cnt_o=5, miss_cnt_o=2.
